// File: rtl/fpu_pkg.sv
// Shared FPU types: rounding-mode encoding and exponent-bias helper.
package fpu_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } rm_e;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fround_pipe_if.sv
// Valid/ready operand and result channels of the round-to-integral unit.
interface fround_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 6
) ();
    import fpu_pkg::*;

    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    rm_e              in_rm;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_c;
    logic             out_inexact;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_rm, in_tag, out_ready,
        input  in_ready, out_valid, out_c, out_inexact, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_rm, in_tag, out_ready,
        output in_ready, out_valid, out_c, out_inexact, out_tag
    );

endinterface

// File: rtl/fround_core.sv
// Combinational FP round-to-integral: {a, rm} -> {c, inexact}; the result stays in FP format.
module fround_core
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] a,
    input  rm_e                  rm,
    output logic [EXP_W+MAN_W:0] c,
    output logic                 inexact
);
    localparam int              BIAS   = bias(EXP_W);
    localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(BIAS);

    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    assign {s, e, m} = a;

    int               f;
    logic [MAN_W-1:0] frac_mask, sticky_mask, g_mask, lsb_mask;
    logic [MAN_W:0]   add_vec, sum;
    logic             g, sticky, lsb, frac_nz, carry, inc;

    // Bit masks keyed off f, the number of fraction bits for this exponent.
    always_comb begin
        f = MAN_W - 1 - (int'(e) - BIAS);
        for (int i = 0; i < MAN_W; i++) begin
            frac_mask[i]   = (i <= f);
            sticky_mask[i] = (i < f);
            g_mask[i]      = (i == f);
            lsb_mask[i]    = (i == f + 1);
        end
        for (int i = 0; i <= MAN_W; i++) begin
            add_vec[i] = (i == f + 1);
        end
    end

    assign frac_nz = |(m & frac_mask);
    assign g       = |(m & g_mask);
    assign sticky  = |(m & sticky_mask);
    assign lsb     = (f == MAN_W - 1) ? 1'b1 : |(m & lsb_mask);

    // {1,int} lies in [2^MAN_W, 2^(MAN_W+1)), so the sum wraps past the top exactly when
    // the implicit-one position clears: that is the carry into the exponent.
    assign sum   = {1'b1, m & ~frac_mask} + add_vec;
    assign carry = ~sum[MAN_W];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        c       = a;
        inexact = 1'b0;
        inc     = 1'b0;
        if (int'(e) >= BIAS + MAN_W) begin
            c = a;
        end else if (e == '0 && m == '0) begin
            c = a;
        end else if (int'(e) < BIAS) begin
            inexact = 1'b1;
            unique case (rm)
                RM_RTZ: c = {s, {(EXP_W + MAN_W){1'b0}}};
                RM_RDN: c = s ? {1'b1, BIAS_E, {MAN_W{1'b0}}} : '0;
                RM_RUP: c = s ? {1'b1, {(EXP_W + MAN_W){1'b0}}} : {1'b0, BIAS_E, {MAN_W{1'b0}}};
                RM_RNE: c = (e == BIAS_E - EXP_W'(1) && m != '0) ? {s, BIAS_E, {MAN_W{1'b0}}}
                                                                 : {s, {(EXP_W + MAN_W){1'b0}}};
            endcase
        end else begin
            inexact = frac_nz;
            unique case (rm)
                RM_RTZ: inc = 1'b0;
                RM_RDN: inc = s & frac_nz;
                RM_RUP: inc = ~s & frac_nz;
                RM_RNE: inc = g & (sticky | lsb);
            endcase
            if (!inc)
                c = {s, e, m & ~frac_mask};
            else if (carry)
                c = {s, e + EXP_W'(1), {MAN_W{1'b0}}};
            else
                c = {s, e, sum[MAN_W-1:0]};
        end
    end

endmodule

// File: rtl/fround_pipe.sv
// Pipelined FP round-to-integral unit: core ahead of stage 1, STAGES-deep register chain behind it.
module fround_pipe
    import fpu_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 2,
    parameter int TAG_W  = 6
) (
    input  logic       clk,
    input  logic       rst,
    fround_pipe_if.slave bus
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic [W-1:0] core_c;
    logic         core_inexact;

    fround_core #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_core (
        .a       (bus.in_a),
        .rm      (bus.in_rm),
        .c       (core_c),
        .inexact (core_inexact)
    );

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] inx_q;
    logic [W-1:0]      c_q   [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic              adv;

    // The whole chain moves together; a held output freezes every stage behind it.
    assign adv          = !vld[STAGES-1] || bus.out_ready;
    assign bus.in_ready = adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are cleared too, so out_c/out_tag/out_inexact read zero after reset.
            vld   <= '0;
            inx_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                c_q[i]   <= '0;
                tag_q[i] <= '0;
            end
        end else if (adv) begin
            // NOTE: non-blocking updates let every stage read its predecessor's old value.
            vld[0]   <= bus.in_valid;
            inx_q[0] <= core_inexact;
            c_q[0]   <= core_c;
            tag_q[0] <= bus.in_tag;
            for (int i = 1; i < STAGES; i++) begin
                vld[i]   <= vld[i-1];
                inx_q[i] <= inx_q[i-1];
                c_q[i]   <= c_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign bus.out_valid   = vld[STAGES-1];
    assign bus.out_inexact = inx_q[STAGES-1];
    assign bus.out_c       = c_q[STAGES-1];
    assign bus.out_tag     = tag_q[STAGES-1];

endmodule

// File: tb/tb_fround_pipe.sv
// Bench for fround_pipe: directed vectors on 1/2/4-stage and double-width builds, random stream vs real-arithmetic model.
module tb_fround_pipe;
    import fpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fround_pipe_if #(.EXP_W(8),  .MAN_W(23), .TAG_W(6)) bus0 ();
    fround_pipe_if #(.EXP_W(8),  .MAN_W(23), .TAG_W(6)) bus1 ();
    fround_pipe_if #(.EXP_W(8),  .MAN_W(23), .TAG_W(6)) bus4 ();
    fround_pipe_if #(.EXP_W(11), .MAN_W(52), .TAG_W(6)) busd ();

    fround_pipe #(.EXP_W(8),  .MAN_W(23), .STAGES(2), .TAG_W(6)) dut  (.clk(clk), .rst(rst), .bus(bus0));
    fround_pipe #(.EXP_W(8),  .MAN_W(23), .STAGES(1), .TAG_W(6)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    fround_pipe #(.EXP_W(8),  .MAN_W(23), .STAGES(4), .TAG_W(6)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
    fround_pipe #(.EXP_W(11), .MAN_W(52), .STAGES(2), .TAG_W(6)) dutd (.clk(clk), .rst(rst), .bus(busd));

    typedef struct {
        logic [31:0] a;
        rm_e         rm;
        logic [31:0] c;
        logic        inx;
    } vec_t;

    typedef struct {
        logic [63:0] a;
        rm_e         rm;
        logic [63:0] c;
        logic        inx;
    } vec64_t;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: exact value in real arithmetic, rounded with floor/ceil, re-encoded as binary32.
    function automatic logic [32:0] ref_round(input logic [31:0] a, input rm_e rm);
        logic   s = a[31];
        int     e = int'(a[30:23]);
        int     m = int'(a[22:0]);
        real    x, r, mag;
        longint n;
        int     k;
        if (e >= 150 || (e == 0 && m == 0)) return {1'b0, a};
        x = (e == 0) ? real'(m) * 2.0 ** (-149) : real'(m + (1 << 23)) * 2.0 ** (e - 150);
        if (s) x = -x;
        case (rm)
            RM_RTZ:  r = s ? $ceil(x) : $floor(x);
            RM_RDN:  r = $floor(x);
            RM_RUP:  r = $ceil(x);
            default: begin
                r = $floor(x);
                if (x - r > 0.5) r = r + 1.0;
                else if (x - r == 0.5 && $floor(r / 2.0) * 2.0 != r) r = r + 1.0;
            end
        endcase
        mag = (r < 0.0) ? -r : r;
        n   = longint'(mag);
        if (n == 0) return {(r != x), s, 31'b0};
        k = 0;
        while ((n >> (k + 1)) != 0) k++;
        return {(r != x), s, 8'(127 + k), 23'((n << (23 - k)) & 64'h7FFFFF)};
    endfunction

    function automatic logic [31:0] rand_op();
        int          pick = int'($urandom_range(0, 15));
        int          sh   = int'($urandom_range(0, 22));
        logic [22:0] m    = 23'($urandom);
        case (pick)
            0:       return {1'($urandom), 31'h0};
            1:       return {1'($urandom), 8'hFF, 23'($urandom_range(0, 1) << 22)};
            2:       return {1'($urandom), 8'h00, m};
            default: begin
                if (pick < 8) m = m & (23'h7FFFFF << sh);
                return {1'($urandom), 8'($urandom_range(110, 152)), m};
            end
        endcase
    endfunction

    task automatic drive_idle();
        bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_rm = RM_RNE; bus0.in_tag = '0; bus0.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_rm = RM_RNE; bus1.in_tag = '0; bus1.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_rm = RM_RNE; bus4.in_tag = '0; bus4.out_ready = 1'b1;
        busd.in_valid = 1'b0; busd.in_a = '0; busd.in_rm = RM_RNE; busd.in_tag = '0; busd.out_ready = 1'b1;
    endtask

    // One op into the 1-, 2- and 4-stage builds; each must present it exactly STAGES edges later.
    task automatic run_vec(input int idx, input vec_t v);
        logic [5:0] t = 6'(idx);
        @(posedge clk); #1;
        bus0.in_valid = 1'b1; bus0.in_a = v.a; bus0.in_rm = v.rm; bus0.in_tag = t;
        bus1.in_valid = 1'b1; bus1.in_a = v.a; bus1.in_rm = v.rm; bus1.in_tag = t;
        bus4.in_valid = 1'b1; bus4.in_a = v.a; bus4.in_rm = v.rm; bus4.in_tag = t;
        for (int d = 1; d <= 4; d++) begin
            @(posedge clk); #1;
            if (d == 1) begin
                bus0.in_valid = 1'b0; bus1.in_valid = 1'b0; bus4.in_valid = 1'b0;
                check($sformatf("vec%0d_s1", idx), 80'({bus1.out_valid, bus1.out_inexact, bus1.out_tag, bus1.out_c}),
                      80'({1'b1, v.inx, t, v.c}));
                check($sformatf("vec%0d_s2_early", idx), 80'(bus0.out_valid), 80'(0));
            end
            if (d == 2)
                check($sformatf("vec%0d_s2", idx), 80'({bus0.out_valid, bus0.out_inexact, bus0.out_tag, bus0.out_c}),
                      80'({1'b1, v.inx, t, v.c}));
            if (d == 3)
                check($sformatf("vec%0d_s4_early", idx), 80'(bus4.out_valid), 80'(0));
            if (d == 4)
                check($sformatf("vec%0d_s4", idx), 80'({bus4.out_valid, bus4.out_inexact, bus4.out_tag, bus4.out_c}),
                      80'({1'b1, v.inx, t, v.c}));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[$];
        vec64_t      vd[$];
        logic [38:0] sb[$];
        logic [38:0] exp_item;
        logic [40:0] held;
        logic        held_v;
        int          lat, stale, accepted;

        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 80'({bus0.out_valid, bus0.out_inexact, bus0.out_tag, bus0.out_c}), 80'(0));
        rst = 1'b0;
        @(negedge clk);
        check("after_reset_outputs", 80'({bus0.out_valid, bus0.out_inexact, bus0.out_tag, bus0.out_c, bus0.in_ready}), 80'(1));

        vecs.push_back('{32'hBFC00000, RM_RDN, 32'hC0000000, 1'b1});
        vecs.push_back('{32'hBE99999A, RM_RDN, 32'hBF800000, 1'b1});
        vecs.push_back('{32'h80000000, RM_RDN, 32'h80000000, 1'b0});
        vecs.push_back('{32'h3FA00000, RM_RUP, 32'h40000000, 1'b1});
        vecs.push_back('{32'hBF000000, RM_RUP, 32'h80000000, 1'b1});
        vecs.push_back('{32'hC0600000, RM_RTZ, 32'hC0400000, 1'b1});
        vecs.push_back('{32'h40200000, RM_RNE, 32'h40000000, 1'b1});
        vecs.push_back('{32'h40600000, RM_RNE, 32'h40800000, 1'b1});
        vecs.push_back('{32'h3F000000, RM_RNE, 32'h00000000, 1'b1});
        vecs.push_back('{32'h3F400000, RM_RNE, 32'h3F800000, 1'b1});
        vecs.push_back('{32'hBFFFFFFF, RM_RDN, 32'hC0000000, 1'b1});
        vecs.push_back('{32'h4B000001, RM_RNE, 32'h4B000001, 1'b0});
        vecs.push_back('{32'h7FC00000, RM_RTZ, 32'h7FC00000, 1'b0});
        vecs.push_back('{32'hFF800000, RM_RUP, 32'hFF800000, 1'b0});
        vecs.push_back('{32'h40100000, RM_RUP, 32'h40400000, 1'b1});
        vecs.push_back('{32'h4AFFFFFF, RM_RTZ, 32'h4AFFFFFE, 1'b1});
        vecs.push_back('{32'h4AFFFFFF, RM_RNE, 32'h4B000000, 1'b1});
        vecs.push_back('{32'h3F800000, RM_RNE, 32'h3F800000, 1'b0});
        vecs.push_back('{32'h3E800000, RM_RUP, 32'h3F800000, 1'b1});
        vecs.push_back('{32'h00000001, RM_RUP, 32'h3F800000, 1'b1});
        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        vd.push_back('{64'hBFF8000000000000, RM_RDN, 64'hC000000000000000, 1'b1});
        vd.push_back('{64'h4004000000000000, RM_RNE, 64'h4000000000000000, 1'b1});
        vd.push_back('{64'hC00C000000000000, RM_RTZ, 64'hC008000000000000, 1'b1});
        for (int i = 0; i < vd.size(); i++) begin
            @(posedge clk); #1;
            busd.in_valid = 1'b1; busd.in_a = vd[i].a; busd.in_rm = vd[i].rm; busd.in_tag = 6'(i);
            @(posedge clk); #1;
            busd.in_valid = 1'b0;
            @(posedge clk); #1;
            check($sformatf("dbl%0d", i), 80'({busd.out_valid, busd.out_inexact, busd.out_tag, busd.out_c}),
                  80'({1'b1, vd[i].inx, 6'(i), vd[i].c}));
        end

        // Latency with an empty pipe and a ready consumer.
        @(posedge clk); #1;
        bus0.in_valid = 1'b1; bus0.in_a = 32'h3FC00000; bus0.in_rm = RM_RNE; bus0.in_tag = 6'd9;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus0.in_valid = 1'b0;
            if (bus0.out_valid && lat < 0) lat = k;
        end
        check("latency", 80'(lat), 80'(2));

        // Reset with two ops in flight.
        @(posedge clk); #1;
        bus0.in_valid = 1'b1; bus0.in_a = 32'h3FC00000; bus0.in_tag = 6'd1;
        @(posedge clk); #1;
        bus0.in_tag = 6'd2;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        check("inflight_before_rst", 80'({bus0.out_valid, bus0.out_tag}), 80'({1'b1, 6'd1}));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_flush", 80'({bus0.out_valid, bus0.out_c}), 80'(0));
        rst = 1'b0;
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus0.out_valid) stale++;
        end
        check("no_stale_after_rst", 80'(stale), 80'(0));

        // Random stream with a randomly stalling consumer.
        held_v   = 1'b0;
        held     = '0;
        accepted = 0;
        for (int cyc = 0; cyc < 330; cyc++) begin
            @(posedge clk); #1;
            if (cyc < 300) begin
                bus0.in_valid = (cyc < 8) ? 1'b1 : ($urandom_range(0, 3) != 0);
                bus0.in_a     = rand_op();
                bus0.in_rm    = rm_e'($urandom_range(0, 3));
                bus0.in_tag   = 6'($urandom);
                bus0.out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                bus0.in_valid  = 1'b0;
                bus0.out_ready = 1'b1;
            end
            @(negedge clk);
            if (held_v)
                check("stall_hold", 80'({bus0.out_valid, bus0.out_inexact, bus0.out_tag, bus0.out_c}), 80'(held));
            if (bus0.in_valid && bus0.in_ready) begin
                sb.push_back({bus0.in_tag, ref_round(bus0.in_a, bus0.in_rm)});
                accepted++;
            end
            if (bus0.out_valid && bus0.out_ready) begin
                if (sb.size() == 0) begin
                    check("stream_extra", 80'(1), 80'(0));
                end else begin
                    exp_item = sb.pop_front();
                    check("stream", 80'({bus0.out_tag, bus0.out_inexact, bus0.out_c}), 80'(exp_item));
                end
            end
            held_v = bus0.out_valid && !bus0.out_ready;
            held   = {bus0.out_valid, bus0.out_inexact, bus0.out_tag, bus0.out_c};
        end
        check("stream_drained", 80'(sb.size()), 80'(0));
        check("stream_ops_accepted", 80'(accepted >= 8), 80'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
